dat_serializer: RTL and testbench
=================================

DAT_SERIALIZER -- requirements
Module: dat_serializer

Interface
REQ-001 Parameter DATA_W, default 32: FIFO word width.
REQ-002 Parameter CRC_W, default 16: per-line CRC length in bits.
REQ-003 Port sd_clock, input, 1: single clock, all state on rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: one-cycle pulse that begins one block write; ignored unless busy=0.
REQ-006 Port Block_Size, input, 12: bytes per block, 4..2048, multiple of 4; sampled on accepted start.
REQ-007 Port wide_bus, input, 1: 1 selects 4-bit DAT[3:0], 0 selects 1-bit DAT[0]; sampled on accepted start.
REQ-008 Port Data_in, input, DATA_W: read data from the asynchronous FIFO (show-ahead, valid while Empty_in=0).
REQ-009 Port Empty_in, input, 1: FIFO empty flag.
REQ-010 Port enable_read, output, 1: one-cycle FIFO pop strobe; Data_in is captured in the same cycle.
REQ-011 Port DAT_out, output, 4: SD DAT line drive values.
REQ-012 Port DAT_oe, output, 1: DAT output enable.
REQ-013 Port busy, output, 1: high from accepted start until return to IDLE.
REQ-014 Port block_done, output, 1: one-cycle pulse in the END_BIT cycle.
REQ-015 Port underrun, output, 1: sticky error flag, cleared by the next accepted start.

Function
REQ-016 The FSM SHALL use the states IDLE, LOAD, START_BIT, DATA, CRC and END_BIT.
REQ-017 IDLE: DAT_oe=0, DAT_out=4'hF, busy=0; start -> LOAD.
REQ-018 LOAD: if Empty_in=0, pulse enable_read, capture the word into the shift register, clear all CRCs -> START_BIT; otherwise stay in LOAD (no timeout).
REQ-019 START_BIT: DAT_oe=1, active lines driven 0 for one cycle -> DATA.
REQ-020 Byte order: Data_in[7:0] first, then [15:8], [23:16], [31:24]; within a byte, MSB first.
REQ-021 4-bit mode: two cycles per byte, high nibble then low nibble on DAT[3:0]; 1-bit mode: eight cycles per byte on DAT[0], with DAT[3:1] driven 1.
REQ-022 The CRC for each active line SHALL be CRC16-CCITT (x^16+x^12+x^5+1), initialised to 0, updated on every DATA cycle with that line's bit.
REQ-023 Prefetch: in the last DATA cycle of each word except the block's final word, if Empty_in=0, pulse enable_read and capture the next word, so no gap appears on DAT.
REQ-024 If Empty_in=1 at a prefetch point, set underrun, drop DAT_oe, and go to IDLE next cycle; block_done is not pulsed.
REQ-025 A 14-bit byte counter SHALL load Block_Size and decrement once per byte sent; DATA -> CRC when it reaches 0.
REQ-026 CRC: 16 cycles, each active line's CRC sent MSB first; inactive lines are driven 1.
REQ-027 END_BIT: active lines driven 1, block_done=1 -> IDLE, where DAT_oe falls.
REQ-028 Block duration SHALL be exactly 2*Block_Size+18 cycles in 4-bit mode and 8*Block_Size+18 cycles in 1-bit mode, counted from START_BIT through END_BIT.
REQ-029 A start pulse while busy=1 SHALL be ignored; Block_Size and wide_bus changes mid-block SHALL have no effect.
REQ-030 enable_read SHALL never assert while Empty_in=1.

Reset
REQ-031 On reset assertion, asynchronously: state=IDLE, DAT_oe=0, DAT_out=4'hF, enable_read=0, busy=0, block_done=0, underrun=0, counters and CRCs=0.
REQ-032 Reset mid-block SHALL abort the block immediately, with no partial CRC or end bit driven.

Structure
REQ-033 Shared package dat_pkg SHALL hold the state encoding, CRC16 polynomial 16'h1021, and the DATA_W/CRC_W defaults.
REQ-034 Sub-module crc16_line (1-bit serial CRC16 with clear, enable and shift-out) SHALL be instantiated four times; lines 3:1 are gated off when wide_bus=0.

Verification
REQ-035 4-bit, Block_Size=4, Data_in=32'h44332211 -> DAT sequence 0,1,1,2,2,3,3,4,4, then 16 CRC nibbles, then F; 26 cycles; block_done once; one enable_read.
REQ-036 1-bit, Block_Size=4, same word -> DAT[0] carries 0, then bits of 11,22,33,44 MSB-first, then CRC16 of those 32 bits, then 1; DAT[3:1]=1 throughout; 50 cycles.
REQ-037 4-bit, Block_Size=512, FIFO never empty -> 128 enable_read pulses, no DAT gaps, 1042 cycles, CRCs match the reference model.
REQ-038 Empty_in forced high at the second prefetch -> underrun=1, DAT_oe=0 next cycle, no block_done; the next start clears underrun.
REQ-039 start with Empty_in=1 for 10 cycles -> held in LOAD with DAT_oe=0, then a normal block once data arrives.
REQ-040 reset asserted mid-DATA -> all outputs at reset values without waiting for a clock edge; a start pulse during busy -> ignored.

Source files
------------

// File: rtl/dat_pkg.sv
// Shared definitions for the SD DAT-line block serializer.
package dat_pkg;

  localparam int unsigned DataWDefault = 32;
  localparam int unsigned CrcWDefault  = 16;

  // CRC16-CCITT, x^16 + x^12 + x^5 + 1
  localparam logic [15:0] CrcPoly = 16'h1021;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStartBit,
    StData,
    StCrc,
    StEndBit
  } dat_state_e;

endpackage

// File: rtl/crc16_line.sv
// Bit-serial CRC16 for one DAT line: clear, fold-in data bits, then stream the remainder MSB first.
module crc16_line
  import dat_pkg::*;
#(
  parameter int unsigned CRC_W = CrcWDefault
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic shift_i,
  input  logic bit_i,
  output logic bit_o
);

  logic [CRC_W-1:0] crc_q;
  logic             fb;

  assign fb    = crc_q[CRC_W-1] ^ bit_i;
  assign bit_o = crc_q[CRC_W-1];

  // Clear wins over update; shift streams out the remainder with zeros behind it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q <= '0;
    end else if (clr_i) begin
      crc_q <= '0;
    end else if (en_i) begin
      crc_q <= {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC_W'(CrcPoly) : '0);
    end else if (shift_i) begin
      crc_q <= {crc_q[CRC_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/dat_serializer.sv
// SD DAT block-write serializer: FIFO words out on 1 or 4 DAT lines with per-line CRC16.
module dat_serializer
  import dat_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned CRC_W  = CrcWDefault
) (
  input  logic              sd_clock,
  input  logic              reset,
  input  logic              start,
  input  logic [11:0]       Block_Size,
  input  logic              wide_bus,
  input  logic [DATA_W-1:0] Data_in,
  input  logic              Empty_in,
  output logic              enable_read,
  output logic [3:0]        DAT_out,
  output logic              DAT_oe,
  output logic              busy,
  output logic              block_done,
  output logic              underrun
);

  localparam int unsigned   CntW     = $clog2(DATA_W + CRC_W);
  localparam logic [CntW-1:0] WordEnd4 = CntW'(DATA_W / 4 - 1);
  localparam logic [CntW-1:0] WordEnd1 = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] CrcEnd   = CntW'(CRC_W - 1);

  dat_state_e        st_q;
  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] word_swapped;
  logic [CntW-1:0]   cnt_q;
  logic [13:0]       byte_cnt_q;
  logic              wide_q;
  logic              underrun_q;

  logic              byte_end;
  logic              word_end;
  logic              last_byte;
  logic              prefetch_pt;
  logic [3:0]        line_bit;
  logic [3:0]        crc_en;
  logic [3:0]        crc_bit;
  logic              crc_clr;
  logic              crc_shift;

  // Reorder so the shifter always sends from its MSB: byte 0 first, each byte MSB first.
  always_comb begin
    word_swapped = '0;
    for (int b = 0; b < DATA_W / 8; b++) begin
      word_swapped[DATA_W-8-8*b +: 8] = Data_in[8*b +: 8];
    end
  end

  assign byte_end    = wide_q ? cnt_q[0] : (cnt_q[2:0] == 3'd7);
  assign word_end    = (cnt_q == (wide_q ? WordEnd4 : WordEnd1));
  assign last_byte   = byte_end && (byte_cnt_q == 14'd1);
  assign prefetch_pt = (st_q == StData) && word_end && !last_byte;

  // Pop is combinational so it can never assert against an empty FIFO.
  assign enable_read = !Empty_in && ((st_q == StLoad) || prefetch_pt);

  assign busy       = (st_q != StIdle);
  assign block_done = (st_q == StEndBit);
  assign underrun   = underrun_q;

  assign line_bit  = wide_q ? sr_q[DATA_W-1 -: 4] : {3'b000, sr_q[DATA_W-1]};
  assign crc_en    = (st_q == StData) ? (wide_q ? 4'hF : 4'h1) : 4'h0;
  assign crc_clr   = (st_q == StLoad) && !Empty_in;
  assign crc_shift = (st_q == StCrc);

  for (genvar i = 0; i < 4; i++) begin : g_crc
    crc16_line #(
      .CRC_W (CRC_W)
    ) u_crc (
      .clk_i   (sd_clock),
      .rst_i   (reset),
      .clr_i   (crc_clr),
      .en_i    (crc_en[i]),
      .shift_i (crc_shift),
      .bit_i   (line_bit[i]),
      .bit_o   (crc_bit[i])
    );
  end

  // Block sequencing: state, shifter, per-word cycle counter and byte counter.
  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      st_q       <= StIdle;
      sr_q       <= '0;
      cnt_q      <= '0;
      byte_cnt_q <= '0;
      wide_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      unique case (st_q)
        StIdle: begin
          if (start) begin
            st_q       <= StLoad;
            byte_cnt_q <= {2'b00, Block_Size};
            wide_q     <= wide_bus;
            underrun_q <= 1'b0;
          end
        end
        StLoad: begin
          if (!Empty_in) begin
            sr_q <= word_swapped;
            st_q <= StStartBit;
          end
        end
        StStartBit: begin
          cnt_q <= '0;
          st_q  <= StData;
        end
        StData: begin
          sr_q  <= wide_q ? (sr_q << 4) : (sr_q << 1);
          cnt_q <= cnt_q + 1'b1;
          if (byte_end) begin
            byte_cnt_q <= byte_cnt_q - 14'd1;
          end
          if (last_byte) begin
            cnt_q <= '0;
            st_q  <= StCrc;
          end else if (word_end) begin
            cnt_q <= '0;
            if (Empty_in) begin
              underrun_q <= 1'b1;
              st_q       <= StIdle;
            end else begin
              sr_q <= word_swapped;
            end
          end
        end
        StCrc: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CrcEnd) begin
            st_q <= StEndBit;
          end
        end
        StEndBit: begin
          st_q <= StIdle;
        end
        default: begin
          st_q <= StIdle;
        end
      endcase
    end
  end

  // DAT line drive decoded from state; inactive lines idle high.
  always_comb begin
    DAT_oe  = 1'b0;
    DAT_out = 4'hF;
    unique case (st_q)
      StStartBit: begin
        DAT_oe  = 1'b1;
        DAT_out = wide_q ? 4'h0 : 4'hE;
      end
      StData: begin
        DAT_oe  = 1'b1;
        DAT_out = wide_q ? sr_q[DATA_W-1 -: 4] : {3'b111, sr_q[DATA_W-1]};
      end
      StCrc: begin
        DAT_oe  = 1'b1;
        DAT_out = wide_q ? crc_bit : {3'b111, crc_bit[0]};
      end
      StEndBit: begin
        DAT_oe  = 1'b1;
        DAT_out = 4'hF;
      end
      default: begin
        DAT_oe  = 1'b0;
        DAT_out = 4'hF;
      end
    endcase
  end

endmodule

// File: tb/tb_dat_serializer.sv
// Scoreboard bench for dat_serializer: expected DAT values queued with the stimulus.
module tb_dat_serializer;

  logic        sd_clock = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] Block_Size;
  logic        wide_bus;
  logic [31:0] Data_in;
  logic        Empty_in;
  logic        enable_read;
  logic [3:0]  DAT_out;
  logic        DAT_oe;
  logic        busy;
  logic        block_done;
  logic        underrun;

  always #5 sd_clock = ~sd_clock;

  dat_serializer #(
    .DATA_W (32),
    .CRC_W  (16)
  ) dut (
    .sd_clock    (sd_clock),
    .reset       (reset),
    .start       (start),
    .Block_Size  (Block_Size),
    .wide_bus    (wide_bus),
    .Data_in     (Data_in),
    .Empty_in    (Empty_in),
    .enable_read (enable_read),
    .DAT_out     (DAT_out),
    .DAT_oe      (DAT_oe),
    .busy        (busy),
    .block_done  (block_done),
    .underrun    (underrun)
  );

  // Show-ahead FIFO model, flushed by reset.
  logic [31:0] fifo_mem [1024];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_base = 0;

  assign Empty_in = (rd_ptr == wr_ptr);
  assign Data_in  = fifo_mem[rd_ptr % 1024];

  always @(posedge sd_clock) begin
    if (reset) rd_ptr <= wr_ptr;
    else if (enable_read) rd_ptr <= rd_ptr + 1;
  end

  logic [3:0]  exp_q[$];
  logic [15:0] m_crc [4];
  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    c  = {c[14:0], 1'b0};
    if (fb) c = c ^ 16'h1021;
    return c;
  endfunction

  task automatic push_word(input logic [31:0] w);
    fifo_mem[wr_ptr % 1024] = w;
    wr_ptr++;
  endtask

  task automatic model_start(input bit wide);
    for (int i = 0; i < 4; i++) m_crc[i] = 16'h0000;
    exp_q.push_back(wide ? 4'h0 : 4'hE);
  endtask

  task automatic model_word(input logic [31:0] w, input bit wide);
    logic [7:0] b;
    logic [3:0] nib;
    for (int j = 0; j < 4; j++) begin
      b = w[8*j +: 8];
      if (wide) begin
        for (int h = 1; h >= 0; h--) begin
          nib = b[4*h +: 4];
          exp_q.push_back(nib);
          for (int i = 0; i < 4; i++) m_crc[i] = crc_step(m_crc[i], nib[i]);
        end
      end else begin
        for (int k = 7; k >= 0; k--) begin
          exp_q.push_back({3'b111, b[k]});
          m_crc[0] = crc_step(m_crc[0], b[k]);
        end
      end
    end
  endtask

  task automatic model_tail(input bit wide);
    for (int n = 15; n >= 0; n--) begin
      if (wide) exp_q.push_back({m_crc[3][n], m_crc[2][n], m_crc[1][n], m_crc[0][n]});
      else      exp_q.push_back({3'b111, m_crc[0][n]});
    end
    exp_q.push_back(4'hF);
  endtask

  // Full block: words into FIFO and model together.
  task automatic queue_block(input bit wide, input int nwords, input logic [31:0] first);
    logic [31:0] w;
    model_start(wide);
    for (int k = 0; k < nwords; k++) begin
      w = (k == 0) ? first : $urandom;
      push_word(w);
      model_word(w, wide);
    end
    model_tail(wide);
  endtask

  // Called at a negedge; returns at the negedge after start drops, with mid-block garbage on
  // the sampled-only inputs.
  task automatic pulse_start(input logic [11:0] size, input bit wide);
    rd_base    = rd_ptr;
    Block_Size = size;
    wide_bus   = wide;
    start      = 1'b1;
    @(negedge sd_clock);
    start      = 1'b0;
    Block_Size = 12'hFFC;
    wide_bus   = ~wide;
  endtask

  task automatic collect(input string name, input int exp_len, input int exp_reads,
                         input int exp_done, input int poke);
    int t = 0;
    int cyc = 0;
    int dones = 0;
    logic [3:0] e;
    while (!DAT_oe && t < 60) begin
      @(negedge sd_clock);
      t++;
    end
    checks++;
    if (DAT_oe !== 1'b1) begin
      errors++;
      $display("FAIL %s oe_rise: DAT_oe=%b want 1 within 60 cycles", name, DAT_oe);
    end
    while (DAT_oe === 1'b1 && cyc < exp_len + 8) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
      checks++;
      if (DAT_out !== e) begin
        errors++;
        $display("FAIL %s dat[%0d]: got %h want %h", name, cyc, DAT_out, e);
      end
      checks++;
      if (enable_read && Empty_in) begin
        errors++;
        $display("FAIL %s pop_empty[%0d]: enable_read=1 want 0 while empty", name, cyc);
      end
      if (block_done === 1'b1) dones++;
      start = (cyc == poke);
      if (cyc == poke) begin
        Block_Size = 12'd8;
        wide_bus   = ~wide_bus;
      end
      cyc++;
      @(negedge sd_clock);
    end
    start = 1'b0;
    checks++;
    if (cyc != exp_len) begin
      errors++;
      $display("FAIL %s length: got %0d cycles want %0d", name, cyc, exp_len);
    end
    checks++;
    if (dones != exp_done) begin
      errors++;
      $display("FAIL %s block_done: got %0d pulses want %0d", name, dones, exp_done);
    end
    checks++;
    if (rd_ptr - rd_base != exp_reads) begin
      errors++;
      $display("FAIL %s reads: got %0d want %0d", name, rd_ptr - rd_base, exp_reads);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s leftover: got %0d unsent values want 0", name, exp_q.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_end: got %b want 0", name, busy);
    end
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({DAT_oe, DAT_out, enable_read, busy, block_done, underrun} !== {1'b0, 4'hF, 4'b0000}) begin
      errors++;
      $display("FAIL %s: oe=%b dat=%h rd=%b busy=%b done=%b urun=%b want 0 f 0 0 0 0", name,
               DAT_oe, DAT_out, enable_read, busy, block_done, underrun);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    Block_Size = 12'd4;
    wide_bus = 1'b1;
    #1;
    check_reset_outputs("reset_state");
    @(negedge sd_clock);
    @(negedge sd_clock);
    reset = 1'b0;
    @(negedge sd_clock);
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_wide_small();
    queue_block(1'b1, 1, 32'h44332211);
    pulse_start(12'd4, 1'b1);
    collect("wide4", 26, 1, 1, -1);
  endtask

  task automatic test_narrow_small();
    queue_block(1'b0, 1, 32'h44332211);
    pulse_start(12'd4, 1'b0);
    collect("narrow4", 50, 1, 1, 20);
    repeat (3) @(negedge sd_clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_start: got %b want 0", busy);
    end
  endtask

  task automatic test_wide_512();
    queue_block(1'b1, 128, 32'hDEADBEEF);
    pulse_start(12'd512, 1'b1);
    collect("wide512", 1042, 128, 1, -1);
  endtask

  task automatic test_back_to_back();
    queue_block(1'b0, 2, 32'h80FF0001);
    pulse_start(12'd8, 1'b0);
    collect("b2b_narrow8", 82, 2, 1, -1);
    queue_block(1'b1, 3, 32'hA5C3F00F);
    pulse_start(12'd12, 1'b1);
    collect("b2b_wide12", 42, 3, 1, -1);
  endtask

  task automatic test_underrun();
    logic [31:0] w;
    model_start(1'b1);
    for (int k = 0; k < 2; k++) begin
      w = $urandom;
      push_word(w);
      model_word(w, 1'b1);
    end
    pulse_start(12'd16, 1'b1);
    collect("underrun", 17, 2, 0, -1);
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_set: got %b want 1", underrun);
    end
    queue_block(1'b1, 1, 32'h01234567);
    pulse_start(12'd4, 1'b1);
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clear: got %b want 0", underrun);
    end
    collect("after_underrun", 26, 1, 1, -1);
  endtask

  task automatic test_load_wait();
    logic [31:0] w;
    w = 32'h5A5AC33C;
    model_start(1'b1);
    model_word(w, 1'b1);
    model_tail(1'b1);
    pulse_start(12'd4, 1'b1);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({DAT_oe, busy, enable_read} !== 3'b010) begin
        errors++;
        $display("FAIL load_wait[%0d]: oe/busy/rd=%b want 010", k, {DAT_oe, busy, enable_read});
      end
      @(negedge sd_clock);
    end
    push_word(w);
    collect("load_wait", 26, 1, 1, -1);
  endtask

  task automatic test_reset_mid();
    int t = 0;
    for (int k = 0; k < 16; k++) push_word($urandom);
    pulse_start(12'd64, 1'b1);
    while (!DAT_oe && t < 60) begin
      @(negedge sd_clock);
      t++;
    end
    repeat (6) @(negedge sd_clock);
    checks++;
    if (DAT_oe !== 1'b1) begin
      errors++;
      $display("FAIL mid_block_active: DAT_oe=%b want 1", DAT_oe);
    end
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_mid_async");
    @(negedge sd_clock);
    @(negedge sd_clock);
    reset = 1'b0;
    @(negedge sd_clock);
    check_reset_outputs("reset_mid_idle");
    queue_block(1'b1, 1, 32'hCAFEF00D);
    pulse_start(12'd4, 1'b1);
    collect("after_reset", 26, 1, 1, -1);
  endtask

  initial begin
    test_reset();
    test_wide_small();
    test_narrow_small();
    test_wide_512();
    test_back_to_back();
    test_underrun();
    test_load_wait();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
